// File: rtl/trdb_pkg.sv
// Shared constants and types for the trace debugger timer packet path.
package trdb_pkg;

  localparam logic [3:0] TRDB_FMT_TIMER  = 4'hC;
  localparam int         TRDB_TIME_HDR_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } trdb_pkt_state_e;

endpackage

// File: rtl/trdb_word_serializer.sv
// Loads a wide packet and presents it LSB word first on a valid/ready stream.
module trdb_word_serializer #(
  parameter int PKT_WIDTH  = 48,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [PKT_WIDTH-1:0]  data,
  output logic                  valid,
  input  logic                  ready,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  last
);

  localparam int NUM_WORDS = (PKT_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int DEPTH     = 2 ** IDX_W;
  localparam int BUF_W     = DEPTH * WORD_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  logic [BUF_W-1:0]      padded;
  logic [WORD_WIDTH-1:0] words [DEPTH];
  logic [IDX_W-1:0]      idx;
  logic                  accept;

  // Unused high words stay zero, which also supplies the pad bits.
  assign padded = BUF_W'(data);
  assign accept = valid && ready;
  assign word   = words[idx];
  assign last   = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      idx   <= '0;
      for (int i = 0; i < DEPTH; i++) words[i] <= '0;
    end else if (load) begin
      valid <= 1'b1;
      idx   <= '0;
      for (int i = 0; i < DEPTH; i++) words[i] <= padded[i*WORD_WIDTH +: WORD_WIDTH];
    end else if (accept) begin
      if (last) valid <= 1'b0;
      else      idx   <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/trdb_time_packetizer.sv
// Grants timer-unit requests, samples the cycle counter and frames it as a
// timer packet streamed out word by word.
module trdb_time_packetizer
  import trdb_pkg::*;
#(
  parameter int TIMER_WIDTH = 40,
  parameter int WORD_WIDTH  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   tu_valid_i,
  output logic                   tu_grant_o,
  input  logic [TIMER_WIDTH-1:0] trdb_time_i,
  output logic                   pkt_valid_o,
  input  logic                   pkt_ready_i,
  output logic [WORD_WIDTH-1:0]  pkt_word_o,
  output logic                   pkt_last_o,
  output logic                   busy_o
);

  localparam int PKT_WIDTH = TRDB_TIME_HDR_W + TIMER_WIDTH;
  localparam int NUM_WORDS = (PKT_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam logic [3:0] HDR_LEN = 4'(NUM_WORDS - 1);

  trdb_pkt_state_e      state;
  logic                 accept;
  logic                 final_accept;
  logic                 load;
  logic [PKT_WIDTH-1:0] packet;

  assign packet = {trdb_time_i, HDR_LEN, TRDB_FMT_TIMER};

  // A new request is only taken when idle or on the closing handshake of the
  // current packet, so the serializer is never overwritten mid-packet.
  always_comb begin
    accept       = pkt_valid_o && pkt_ready_i;
    final_accept = (state == EMIT) && accept && pkt_last_o;
    load         = !rst_i && tu_valid_i && enable_i && ((state == IDLE) || final_accept);
    tu_grant_o   = !rst_i && tu_valid_i && ((state == IDLE) || (final_accept && enable_i));
    busy_o       = (state == EMIT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (load) state <= EMIT;
        EMIT:    if (final_accept && !load) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  trdb_word_serializer #(
    .PKT_WIDTH  (PKT_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_serializer (
    .clk   (clk_i),
    .rst   (rst_i),
    .load  (load),
    .data  (packet),
    .valid (pkt_valid_o),
    .ready (pkt_ready_i),
    .word  (pkt_word_o),
    .last  (pkt_last_o)
  );

endmodule

// File: tb/tb_trdb_time_packetizer.sv
// Bench for trdb_time_packetizer: directed scenarios plus a randomized run
// against a word-queue reference model.
module tb_trdb_time_packetizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, tu_valid, ready;
  logic [39:0] tstamp;
  logic        grant, pvalid, plast, busy;
  logic [31:0] pword;

  logic        rst_b, enable_b, tu_valid_b, ready_b;
  logic [23:0] tstamp_b;
  logic        grant_b, pvalid_b, plast_b, busy_b;
  logic [31:0] pword_b;

  int compared = 0;
  int mismatched = 0;

  trdb_time_packetizer #(.TIMER_WIDTH(40), .WORD_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .tu_valid_i(tu_valid),
    .tu_grant_o(grant), .trdb_time_i(tstamp), .pkt_valid_o(pvalid),
    .pkt_ready_i(ready), .pkt_word_o(pword), .pkt_last_o(plast), .busy_o(busy)
  );

  trdb_time_packetizer #(.TIMER_WIDTH(24), .WORD_WIDTH(32)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .enable_i(enable_b), .tu_valid_i(tu_valid_b),
    .tu_grant_o(grant_b), .trdb_time_i(tstamp_b), .pkt_valid_o(pvalid_b),
    .pkt_ready_i(ready_b), .pkt_word_o(pword_b), .pkt_last_o(plast_b), .busy_o(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference packet for the 40-bit / 32-bit configuration: header + stamp.
  function automatic logic [31:0] ref_word(input logic [39:0] t, input int i);
    logic [127:0] p;
    int nwords;
    nwords = (8 + 40 + 31) / 32;
    p = 128'(t) * 256 + 128'((nwords - 1) * 16 + 12);
    return 32'(p >> (32 * i));
  endfunction

  task automatic test_reset();
    rst = 1; tu_valid = 1; enable = 1; ready = 1; tstamp = 40'h1;
    rst_b = 1; tu_valid_b = 0; enable_b = 1; ready_b = 1; tstamp_b = 24'h0;
    tick(); tick();
    #1;
    compared++; if (grant !== 1'b0) begin mismatched++; $display("FAIL reset_grant got=%b want=0", grant); end
    compared++; if (pvalid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got=%b want=0", pvalid); end
    compared++; if (plast !== 1'b0) begin mismatched++; $display("FAIL reset_last got=%b want=0", plast); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b want=0", busy); end
    compared++; if (pword !== 32'h0) begin mismatched++; $display("FAIL reset_word got=%h want=0", pword); end
    rst = 0; rst_b = 0; tu_valid = 0;
    tick();
  endtask

  task automatic test_single();
    enable = 1; ready = 1; tstamp = 40'h12_3456_789A; tu_valid = 1;
    #1;
    compared++; if (grant !== 1'b1) begin mismatched++; $display("FAIL single_grant got=%b want=1", grant); end
    tick(); tu_valid = 0; tstamp = 40'hFF_FFFF_FFFF; #1;
    compared++; if (pvalid !== 1'b1 || pword !== 32'h5678_9A1C || plast !== 1'b0)
      begin mismatched++; $display("FAIL single_w0 got=%b/%h/%b want=1/56789a1c/0", pvalid, pword, plast); end
    tick(); #1;
    compared++; if (pvalid !== 1'b1 || pword !== 32'h0000_1234 || plast !== 1'b1)
      begin mismatched++; $display("FAIL single_w1 got=%b/%h/%b want=1/00001234/1", pvalid, pword, plast); end
    tick(); #1;
    compared++; if (pvalid !== 1'b0 || busy !== 1'b0)
      begin mismatched++; $display("FAIL single_idle got=%b/%b want=0/0", pvalid, busy); end
  endtask

  task automatic test_backpressure();
    enable = 1; ready = 0; tstamp = 40'h12_3456_789A; tu_valid = 1;
    tick(); tstamp = 40'hAA_BBCC_DDEE;
    for (int i = 0; i < 5; i++) begin
      #1;
      compared++; if (pvalid !== 1'b1 || pword !== 32'h5678_9A1C || plast !== 1'b0 || grant !== 1'b0)
        begin mismatched++; $display("FAIL bp_hold%0d got=%b/%h/%b/g%b want=1/56789a1c/0/g0", i, pvalid, pword, plast, grant); end
      tick();
    end
    tu_valid = 0; ready = 1; #1;
    compared++; if (pvalid !== 1'b1 || pword !== 32'h5678_9A1C)
      begin mismatched++; $display("FAIL bp_w0 got=%b/%h want=1/56789a1c", pvalid, pword); end
    tick(); #1;
    compared++; if (pvalid !== 1'b1 || pword !== 32'h0000_1234 || plast !== 1'b1)
      begin mismatched++; $display("FAIL bp_w1 got=%b/%h/%b want=1/00001234/1", pvalid, pword, plast); end
    tick(); #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL bp_idle busy=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    enable = 1; ready = 1; tstamp = 40'h12_3456_789A; tu_valid = 1;
    tick(); #1;
    compared++; if (grant !== 1'b0) begin mismatched++; $display("FAIL b2b_nogrant got=%b want=0", grant); end
    tick(); tstamp = 40'h5; #1;
    compared++; if (grant !== 1'b1 || plast !== 1'b1)
      begin mismatched++; $display("FAIL b2b_grant got=%b last=%b want=1/1", grant, plast); end
    tick(); tu_valid = 0; #1;
    compared++; if (pvalid !== 1'b1 || pword !== 32'h0000_051C || plast !== 1'b0)
      begin mismatched++; $display("FAIL b2b_w0 got=%b/%h/%b want=1/0000051c/0", pvalid, pword, plast); end
    tick(); #1;
    compared++; if (pword !== 32'h0 || plast !== 1'b1)
      begin mismatched++; $display("FAIL b2b_w1 got=%h/%b want=00000000/1", pword, plast); end
    tick();
  endtask

  task automatic test_disabled();
    enable = 0; ready = 1; tu_valid = 1; tstamp = 40'h77; #1;
    compared++; if (grant !== 1'b1) begin mismatched++; $display("FAIL dis_grant got=%b want=1", grant); end
    tick(); tu_valid = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      compared++; if (pvalid !== 1'b0 || busy !== 1'b0)
        begin mismatched++; $display("FAIL dis_quiet%0d got=%b/%b want=0/0", i, pvalid, busy); end
      tick();
    end
    enable = 1;
  endtask

  task automatic test_reset_mid();
    enable = 1; ready = 0; tstamp = 40'h12_3456_789A; tu_valid = 1;
    tick(); rst = 1; #1;
    compared++; if (grant !== 1'b0) begin mismatched++; $display("FAIL rstmid_grant got=%b want=0", grant); end
    tick(); rst = 0; tu_valid = 0; #1;
    compared++; if (pvalid !== 1'b0 || busy !== 1'b0)
      begin mismatched++; $display("FAIL rstmid_clear got=%b/%b want=0/0", pvalid, busy); end
    ready = 1; tstamp = 40'hDE_AD00_BEEF; tu_valid = 1; #1;
    compared++; if (grant !== 1'b1) begin mismatched++; $display("FAIL rstmid_regrant got=%b want=1", grant); end
    tick(); tu_valid = 0; #1;
    compared++; if (pword !== ref_word(40'hDE_AD00_BEEF, 0))
      begin mismatched++; $display("FAIL rstmid_w0 got=%h want=%h", pword, ref_word(40'hDE_AD00_BEEF, 0)); end
    tick(); #1;
    compared++; if (pword !== ref_word(40'hDE_AD00_BEEF, 1) || plast !== 1'b1)
      begin mismatched++; $display("FAIL rstmid_w1 got=%h/%b want=%h/1", pword, plast, ref_word(40'hDE_AD00_BEEF, 1)); end
    tick();
  endtask

  task automatic test_sweep();
    enable_b = 1; ready_b = 0; tstamp_b = 24'hAB_CDEF; tu_valid_b = 1; #1;
    compared++; if (grant_b !== 1'b1) begin mismatched++; $display("FAIL sweep_grant got=%b want=1", grant_b); end
    tick(); tu_valid_b = 0; #1;
    compared++; if (pvalid_b !== 1'b1 || pword_b !== 32'hABCD_EF0C || plast_b !== 1'b1)
      begin mismatched++; $display("FAIL sweep_word got=%b/%h/%b want=1/abcdef0c/1", pvalid_b, pword_b, plast_b); end
    ready_b = 1;
    tick(); #1;
    compared++; if (pvalid_b !== 1'b0 || busy_b !== 1'b0)
      begin mismatched++; $display("FAIL sweep_idle got=%b/%b want=0/0", pvalid_b, busy_b); end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [63:0] r;
    logic exp_valid, acc, exp_grant;
    tu_valid = 0; enable = 1; ready = 1;
    for (int c = 0; c < 400; c++) begin
      r = {$urandom, $urandom};
      tstamp   = r[39:0];
      tu_valid = ($urandom_range(0, 2) != 0);
      enable   = ($urandom_range(0, 7) != 0);
      ready    = ($urandom_range(0, 3) != 0);
      #1;
      exp_valid = (q.size() != 0);
      acc       = exp_valid && ready;
      exp_grant = tu_valid && (!exp_valid || (acc && q.size() == 1 && enable));
      compared++; if (pvalid !== exp_valid || busy !== exp_valid)
        begin mismatched++; $display("FAIL rnd_valid c=%0d got=%b/%b want=%b", c, pvalid, busy, exp_valid); end
      if (exp_valid) begin
        compared++; if (pword !== q[0] || plast !== (q.size() == 1))
          begin mismatched++; $display("FAIL rnd_word c=%0d got=%h/%b want=%h/%b", c, pword, plast, q[0], q.size() == 1); end
      end
      compared++; if (grant !== exp_grant)
        begin mismatched++; $display("FAIL rnd_grant c=%0d got=%b want=%b", c, grant, exp_grant); end
      if (acc) void'(q.pop_front());
      if (exp_grant && enable) begin
        q.push_back(ref_word(tstamp, 0));
        q.push_back(ref_word(tstamp, 1));
      end
      tick();
    end
    tu_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_disabled();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
